// File: rtl/aes128_rand_pair_dist_if.sv
// Handshake bundle for the randomness pair distributor.
// Optional abort_i exists only when AES128_PAIR_DIST_ABORT_EN is defined.
//
// Valid/ready rule used on both streams: a word transfers on a rising clock edge
// exactly when valid and ready are both high in the cycle before that edge. The
// producer holds data stable while valid is high and ready is low. The
// distributor's in_ready_o depends combinationally on out_ready_i only.
interface aes128_rand_pair_dist_if #(
    parameter int NUM_SHARES = 3,
    parameter int WIDTH      = 8
);
    localparam int N_QUAD = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int IW_RAW = $clog2(NUM_SHARES);
    localparam int KW_RAW = $clog2(N_QUAD);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;
    localparam int KW     = (KW_RAW < 1) ? 1 : KW_RAW;

    logic             start_i;
    logic [WIDTH-1:0] in_rand_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] out_rand_o;
    logic [IW-1:0]    out_i_o;
    logic [IW-1:0]    out_j_o;
    logic [KW-1:0]    out_k_o;
    logic             out_last_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic             busy_o;
    logic             done_o;
    logic [1:0]       state_o;
`ifdef AES128_PAIR_DIST_ABORT_EN
    logic             abort_i;
`endif

    modport slave (
        input  start_i, in_rand_i, in_valid_i, out_ready_i,
`ifdef AES128_PAIR_DIST_ABORT_EN
        input  abort_i,
`endif
        output in_ready_o, out_rand_o, out_i_o, out_j_o, out_k_o,
        output out_last_o, out_valid_o, busy_o, done_o, state_o
    );

    modport master (
        output start_i, in_rand_i, in_valid_i, out_ready_i,
`ifdef AES128_PAIR_DIST_ABORT_EN
        output abort_i,
`endif
        input  in_ready_o, out_rand_o, out_i_o, out_j_o, out_k_o,
        input  out_last_o, out_valid_o, busy_o, done_o, state_o
    );
endinterface

// File: rtl/aes128_rand_pair_dist.sv
// Randomness distributor for the masked AES datapath.
// Walks all unordered share pairs (i,j), i<j, in dense order
// (0,1),(0,2)..(0,N-1),(1,2)..(N-2,N-1) and tags each accepted fresh-random
// word with its pair and running index k. One batch per start_i.
// Optional feature: define AES128_PAIR_DIST_ABORT_EN to add abort_i, which
// drops the batch in RUN/DRAIN without a done_o pulse.
// state_o exposes the FSM encoding: 0 IDLE, 1 RUN, 2 DRAIN.
module aes128_rand_pair_dist #(
    parameter int NUM_SHARES = 3,
    parameter int WIDTH      = 8
) (
    input logic                   clk_i,
    input logic                   rst_i,
    aes128_rand_pair_dist_if.slave bus
);
    localparam int N_QUAD = NUM_SHARES * (NUM_SHARES - 1) / 2;
    localparam int IW_RAW = $clog2(NUM_SHARES);
    localparam int KW_RAW = $clog2(N_QUAD);
    localparam int IW     = (IW_RAW < 1) ? 1 : IW_RAW;
    localparam int KW     = (KW_RAW < 1) ? 1 : KW_RAW;

    if (NUM_SHARES < 2) begin : g_bad_num_shares
        $error("aes128_rand_pair_dist: NUM_SHARES must be >= 2");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;

    logic [IW-1:0]    i_q;
    logic [IW-1:0]    j_q;
    logic [KW-1:0]    k_q;

    logic [WIDTH-1:0] out_rand_q;
    logic [IW-1:0]    out_i_q;
    logic [IW-1:0]    out_j_q;
    logic [KW-1:0]    out_k_q;
    logic             out_last_q;
    logic             out_valid_q;
    logic             done_q;

    logic             busy;
    logic             in_ready;
    logic             accept;
    logic             out_hs;
    logic             k_last;
    logic             j_top;
    logic             abort;

`ifdef AES128_PAIR_DIST_ABORT_EN
    // Abort only has meaning while a batch is in flight.
    assign abort = bus.abort_i && (state_q != IDLE);
`else
    assign abort = 1'b0;
`endif

    assign accept = bus.in_valid_i && in_ready;
    assign out_hs = out_valid_q && bus.out_ready_i;
    assign k_last = (k_q == KW'(N_QUAD - 1));
    assign j_top  = (j_q == IW'(NUM_SHARES - 1));

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: start opens a batch, the last accept drains, the last output handshake closes it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start_i) state_d = RUN;
            RUN:     if (accept && k_last) state_d = DRAIN;
            DRAIN:   if (out_hs && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    // State-derived outputs; the input side opens whenever the output register can take a word.
    always_comb begin
        busy     = (state_q != IDLE);
        in_ready = (state_q == RUN) && (!out_valid_q || bus.out_ready_i);
    end

    // Pair walker: step (i,j,k) on every accepted word, back to (0,1,0) after the final pair.
    always_ff @(posedge clk_i) begin
        if (rst_i || abort) begin
            i_q <= '0;
            j_q <= IW'(1);
            k_q <= '0;
        end else if (accept) begin
            if (k_last) begin
                i_q <= '0;
                j_q <= IW'(1);
                k_q <= '0;
            end else begin
                if (j_top) begin
                    i_q <= i_q + IW'(1);
                    j_q <= i_q + IW'(2);
                end else begin
                    j_q <= j_q + IW'(1);
                end
                k_q <= k_q + KW'(1);
            end
        end
    end

    // Output register: load word with pre-step tag on accept, clear valid on a lone handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_rand_q  <= '0;
            out_i_q     <= '0;
            out_j_q     <= '0;
            out_k_q     <= '0;
            out_last_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (abort) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_rand_q  <= bus.in_rand_i;
            out_i_q     <= i_q;
            out_j_q     <= j_q;
            out_k_q     <= k_q;
            out_last_q  <= k_last;
            out_valid_q <= 1'b1;
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    // Completion pulse one cycle after the last pair leaves; an abort suppresses it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            done_q <= 1'b0;
        end else begin
            done_q <= !abort && (state_q == DRAIN) && out_hs && out_last_q;
        end
    end

    assign bus.in_ready_o  = in_ready;
    assign bus.out_rand_o  = out_rand_q;
    assign bus.out_i_o     = out_i_q;
    assign bus.out_j_o     = out_j_q;
    assign bus.out_k_o     = out_k_q;
    assign bus.out_last_o  = out_last_q;
    assign bus.out_valid_o = out_valid_q;
    assign bus.busy_o      = busy;
    assign bus.done_o      = done_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_aes128_rand_pair_dist.sv
// Bench for aes128_rand_pair_dist: three instances (N=3,4,5) share the stimulus
// bus; each has its own start bit, so only the selected one is ever in RUN.
`timescale 1ns/1ps
module tb_aes128_rand_pair_dist;
    localparam int W  = 8;
    localparam int EW = W + 3 + 3 + 4 + 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic [2:0]        start;
    logic [W-1:0]      in_rand;
    logic              in_valid;
    logic              out_ready;
    logic              abort;

    logic [2:0]        o_valid, o_last, o_busy, o_done, o_in_ready;
    logic [2:0][W-1:0] o_rand;
    logic [2:0][2:0]   o_i, o_j;
    logic [2:0][3:0]   o_k;
    logic [2:0][1:0]   o_state;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int N = g + 3;
        aes128_rand_pair_dist_if #(.NUM_SHARES(N), .WIDTH(W)) bus ();
        assign bus.start_i     = start[g];
        assign bus.in_rand_i   = in_rand;
        assign bus.in_valid_i  = in_valid;
        assign bus.out_ready_i = out_ready;
`ifdef AES128_PAIR_DIST_ABORT_EN
        assign bus.abort_i     = abort;
`endif
        assign o_valid[g]    = bus.out_valid_o;
        assign o_last[g]     = bus.out_last_o;
        assign o_busy[g]     = bus.busy_o;
        assign o_done[g]     = bus.done_o;
        assign o_in_ready[g] = bus.in_ready_o;
        assign o_rand[g]     = bus.out_rand_o;
        assign o_i[g]        = 3'(bus.out_i_o);
        assign o_j[g]        = 3'(bus.out_j_o);
        assign o_k[g]        = 4'(bus.out_k_o);
        assign o_state[g]    = bus.state_o;
        aes128_rand_pair_dist #(.NUM_SHARES(N), .WIDTH(W)) dut (
            .clk_i (clk),
            .rst_i (rst),
            .bus   (bus)
        );
    end

    // checking
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // scoreboard
    logic [EW-1:0] exp_q0[$];
    logic [EW-1:0] exp_q1[$];
    logic [EW-1:0] exp_q2[$];

    function automatic logic [EW-1:0] pack(input logic [W-1:0] r, input logic [2:0] i,
                                           input logic [2:0] j, input logic [3:0] k,
                                           input logic last);
        return {r, i, j, k, last};
    endfunction

    // Reference pair for index k, by enumerating i<j in order.
    function automatic logic [5:0] pair_of(input int n_sh, input int k);
        int c;
        c = 0;
        for (int i = 0; i < n_sh; i++) begin
            for (int j = i + 1; j < n_sh; j++) begin
                if (c == k) return {3'(i), 3'(j)};
                c++;
            end
        end
        return 6'h3f;
    endfunction

    function automatic int qsize(input int n);
        case (n)
            0:       return exp_q0.size();
            1:       return exp_q1.size();
            default: return exp_q2.size();
        endcase
    endfunction

    task automatic push_exp(input int n, input logic [EW-1:0] v);
        case (n)
            0:       exp_q0.push_back(v);
            1:       exp_q1.push_back(v);
            default: exp_q2.push_back(v);
        endcase
    endtask

    task automatic pop_exp(input int n, output logic [EW-1:0] v);
        case (n)
            0:       v = exp_q0.pop_front();
            1:       v = exp_q1.pop_front();
            default: v = exp_q2.pop_front();
        endcase
    endtask

    task automatic flush_exp(input int n);
        case (n)
            0:       exp_q0.delete();
            1:       exp_q1.delete();
            default: exp_q2.delete();
        endcase
    endtask

    int       acc_k[3];
    int       done_cnt[3];
    int       hs_cnt[3];
    bit [2:0] exp_done;

    // Monitor: predicts accepts/handshakes that the next rising edge will perform.
    always @(negedge clk) begin
        for (int n = 0; n < 3; n++) begin
            int            nsh;
            int            nq;
            logic [EW-1:0] e;
            logic [5:0]    p;
            nsh = n + 3;
            nq  = nsh * (nsh - 1) / 2;
            check_eq($sformatf("done_n%0d", nsh), 32'(o_done[n]), 32'(exp_done[n]));
            if (exp_done[n]) check_eq($sformatf("busy_after_done_n%0d", nsh), 32'(o_busy[n]), 32'd0);
            if (o_done[n]) done_cnt[n]++;
            exp_done[n] = 1'b0;
            if (rst || abort) begin
                flush_exp(n);
                acc_k[n] = 0;
            end else begin
                if (o_valid[n] && out_ready) begin
                    check_eq($sformatf("pending_n%0d", nsh), 32'(qsize(n)), 32'd1);
                    if (qsize(n) > 0) begin
                        pop_exp(n, e);
                        check_eq($sformatf("pair_n%0d", nsh),
                                 32'(pack(o_rand[n], o_i[n], o_j[n], o_k[n], o_last[n])), 32'(e));
                    end
                    hs_cnt[n]++;
                    exp_done[n] = (e[0] == 1'b1);
                end
                if (in_valid && o_in_ready[n]) begin
                    p = pair_of(nsh, acc_k[n]);
                    push_exp(n, pack(in_rand, p[5:3], p[2:0], 4'(acc_k[n]), acc_k[n] == nq - 1));
                    acc_k[n] = (acc_k[n] == nq - 1) ? 0 : acc_k[n] + 1;
                end
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_batch(input int n);
        start[n] = 1'b1;
        step();
        start[n] = 1'b0;
    endtask

    task automatic wait_done(input int n, input int budget, input string tag);
        int base;
        base = done_cnt[n];
        for (int c = 0; c < budget; c++) begin
            if (done_cnt[n] != base) break;
            step();
        end
        check_eq({tag, "_done_seen"}, 32'(done_cnt[n] - base), 32'd1);
        repeat (3) step();
        check_eq({tag, "_single_done"}, 32'(done_cnt[n] - base), 32'd1);
        check_eq({tag, "_q_empty"}, 32'(qsize(n)), 32'd0);
    endtask

    task automatic feed_continuous(input int n, input int words);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < words; c++) begin
            in_rand = W'($urandom_range(0, 255));
            step();
        end
        in_valid = 1'b0;
    endtask

    int hs_base;
    int done_base;
    logic [W-1:0] w0;

    initial begin
        rst = 1'b1; start = '0; in_rand = '0; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
        repeat (3) step();

        // reset state of every instance
        for (int n = 0; n < 3; n++) begin
            check_eq("rst_valid", 32'(o_valid[n]), 32'd0);
            check_eq("rst_rand", 32'(o_rand[n]), 32'd0);
            check_eq("rst_i", 32'(o_i[n]), 32'd0);
            check_eq("rst_j", 32'(o_j[n]), 32'd0);
            check_eq("rst_k", 32'(o_k[n]), 32'd0);
            check_eq("rst_last", 32'(o_last[n]), 32'd0);
            check_eq("rst_busy", 32'(o_busy[n]), 32'd0);
            check_eq("rst_done", 32'(o_done[n]), 32'd0);
            check_eq("rst_in_ready", 32'(o_in_ready[n]), 32'd0);
            check_eq("rst_state", 32'(o_state[n]), 32'd0);
        end
        rst = 1'b0;
        step();

        // N=3 directed words A0,A1,A2
        hs_base = hs_cnt[0];
        start_batch(0);
        check_eq("n3_busy", 32'(o_busy[0]), 32'd1);
        in_valid = 1'b1; out_ready = 1'b1;
        in_rand = 8'hA0; step();
        in_rand = 8'hA1; step();
        in_rand = 8'hA2; step();
        in_valid = 1'b0;
        check_eq("n3_last_flag", 32'(o_last[0]), 32'd1);
        check_eq("n3_last_pair", 32'({o_i[0], o_j[0], o_k[0]}), 32'({3'd1, 3'd2, 4'd2}));
        wait_done(0, 50, "n3");
        check_eq("n3_hs", 32'(hs_cnt[0] - hs_base), 32'd3);

        // N=4 continuous: one pair per cycle, no gaps
        hs_base = hs_cnt[1];
        start_batch(1);
        in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            in_rand = W'($urandom_range(0, 255));
            step();
            check_eq("n4_gapless_valid", 32'(o_valid[1]), 32'd1);
            check_eq("n4_k_seq", 32'(o_k[1]), 32'(c));
        end
        in_valid = 1'b0;
        check_eq("n4_drain_state", 32'(o_state[1]), 32'd2);
        wait_done(1, 50, "n4");
        check_eq("n4_hs", 32'(hs_cnt[1] - hs_base), 32'd6);

        // N=3 consumer stall for 5 cycles after the first word
        start_batch(0);
        w0 = W'($urandom_range(0, 255));
        in_valid = 1'b1; out_ready = 1'b0; in_rand = w0;
        step();
        for (int c = 0; c < 5; c++) begin
            in_rand = W'($urandom_range(0, 255));
            step();
            check_eq("stall_valid", 32'(o_valid[0]), 32'd1);
            check_eq("stall_word", 32'(o_rand[0]), 32'(w0));
            check_eq("stall_k", 32'(o_k[0]), 32'd0);
            check_eq("stall_in_ready", 32'(o_in_ready[0]), 32'd0);
        end
        out_ready = 1'b1;
        step(); step();
        in_valid = 1'b0;
        wait_done(0, 50, "stall");

        // N=5 random valid/ready
        hs_base = hs_cnt[2];
        done_base = done_cnt[2];
        start_batch(2);
        for (int c = 0; c < 3000; c++) begin
            if (done_cnt[2] != done_base) break;
            in_valid  = 1'($urandom_range(0, 1));
            in_rand   = W'($urandom_range(0, 255));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        check_eq("n5_done_count", 32'(done_cnt[2] - done_base), 32'd1);
        check_eq("n5_hs", 32'(hs_cnt[2] - hs_base), 32'd10);
        check_eq("n5_q_empty", 32'(qsize(2)), 32'd0);

        // N=4 reset after the second accept, then restart
        done_base = done_cnt[1];
        start_batch(1);
        in_valid = 1'b1; out_ready = 1'b1;
        in_rand = 8'h5A; step();
        in_rand = 8'hC3; step();
        rst = 1'b1;
        step();
        check_eq("mid_rst_valid", 32'(o_valid[1]), 32'd0);
        check_eq("mid_rst_rand", 32'(o_rand[1]), 32'd0);
        check_eq("mid_rst_k", 32'(o_k[1]), 32'd0);
        check_eq("mid_rst_busy", 32'(o_busy[1]), 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        repeat (2) step();
        check_eq("mid_rst_no_done", 32'(done_cnt[1] - done_base), 32'd0);
        hs_base = hs_cnt[1];
        start_batch(1);
        feed_continuous(1, 6);
        wait_done(1, 50, "restart");
        check_eq("restart_hs", 32'(hs_cnt[1] - hs_base), 32'd6);

`ifdef AES128_PAIR_DIST_ABORT_EN
        // N=3 abort while draining the last pair
        done_base = done_cnt[0];
        start_batch(0);
        in_valid = 1'b1; out_ready = 1'b1;
        in_rand = 8'h11; step();
        in_rand = 8'h22; step();
        in_rand = 8'h33; step();
        check_eq("abort_pre_state", 32'(o_state[0]), 32'd2);
        check_eq("abort_pre_last", 32'(o_last[0]), 32'd1);
        in_valid = 1'b0; out_ready = 1'b0; abort = 1'b1;
        step();
        abort = 1'b0;
        check_eq("abort_valid", 32'(o_valid[0]), 32'd0);
        check_eq("abort_busy", 32'(o_busy[0]), 32'd0);
        check_eq("abort_in_ready", 32'(o_in_ready[0]), 32'd0);
        repeat (3) step();
        check_eq("abort_no_done", 32'(done_cnt[0] - done_base), 32'd0);
        hs_base = hs_cnt[0];
        start_batch(0);
        feed_continuous(0, 3);
        wait_done(0, 50, "replay");
        check_eq("replay_hs", 32'(hs_cnt[0] - hs_base), 32'd3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
